dac_burst_ctrl: RTL

DAC_BURST_CTRL -- requirements
Module: dac_burst_ctrl

---
 rtl/dac_burst_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dac_burst_ctrl.sv
// Burst player: streams cfg_len samples per burst from a dual-channel waveform memory to a DAC,
// cfg_bursts times with cfg_gap idle cycles between bursts. Define DAC_BURST_CTRL_EXT_TRIG_EN to wait for a trig rising edge.
module dac_burst_ctrl #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  trig,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_bursts,
  input  logic [CNT_WIDTH-1:0]  cfg_gap,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dat0,
  input  logic [DATA_WIDTH-1:0] mem_dat1,
  output logic [DATA_WIDTH-1:0] dac0,
  output logic [DATA_WIDTH-1:0] dac1,
  output logic                  dac_ce,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0]   LEN_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
`ifdef DAC_BURST_CTRL_EXT_TRIG_EN
    S_WAIT_TRIG = 3'd1,
`endif
    S_PLAY      = 3'd2,
    S_GAP       = 3'd3,
    S_FLUSH     = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]  burst_q, burst_d;
  logic [CNT_WIDTH-1:0]  gap_q, gap_d;
  logic [CNT_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  flush_q, flush_d;
  logic                  mem_en_q, mem_en_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  dac_ce_q, dac_ce_d;
  logic [DATA_WIDTH-1:0] dac0_q, dac0_d;
  logic [DATA_WIDTH-1:0] dac1_q, dac1_d;
  logic                  done_q, done_d;

  logic abort;
  logic start_ok;
  logic last_addr;
  logic trig_rise;

`ifdef DAC_BURST_CTRL_EXT_TRIG_EN
  logic trig_prev_q, trig_prev_d;
  assign trig_prev_d = trig;
  assign trig_rise   = trig && !trig_prev_q;
`else
  logic trig_unused;
  assign trig_unused = trig;
  assign trig_rise   = 1'b0;
`endif

  // stop wins over every other event, and a start arriving with stop is dropped as well
  assign abort     = stop && (state_q != S_IDLE);
  assign start_ok  = start && !stop && (cfg_len != '0) && (cfg_bursts != '0);
  assign last_addr = ({1'b0, addr_q} == (len_q - LEN_ONE));

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      burst_q   <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      addr_q    <= '0;
      flush_q   <= 1'b0;
      mem_en_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      dac_ce_q  <= 1'b0;
      dac0_q    <= '0;
      dac1_q    <= '0;
      done_q    <= 1'b0;
`ifdef DAC_BURST_CTRL_EXT_TRIG_EN
      trig_prev_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      addr_q    <= addr_d;
      flush_q   <= flush_d;
      mem_en_q  <= mem_en_d;
      rd_vld_q  <= rd_vld_d;
      dac_ce_q  <= dac_ce_d;
      dac0_q    <= dac0_d;
      dac1_q    <= dac1_d;
      done_q    <= done_d;
`ifdef DAC_BURST_CTRL_EXT_TRIG_EN
      trig_prev_q <= trig_prev_d;
`endif
    end
  end

  // Next-state and counter logic
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    len_d     = len_q;
    burst_d   = burst_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    addr_d    = addr_q;
    flush_d   = flush_q;
    done_d    = 1'b0;

    if (abort) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      gap_cnt_d = '0;
      flush_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            len_d   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            burst_d = cfg_bursts;
            gap_d   = cfg_gap;
            addr_d  = '0;
`ifdef DAC_BURST_CTRL_EXT_TRIG_EN
            state_d = S_WAIT_TRIG;
`else
            state_d = S_PLAY;
`endif
          end
        end
`ifdef DAC_BURST_CTRL_EXT_TRIG_EN
        S_WAIT_TRIG: begin
          if (trig_rise) state_d = S_PLAY;
        end
`endif
        S_PLAY: begin
          if (last_addr) begin
            addr_d = '0;
            if (burst_q > CNT_ONE) begin
              burst_d = burst_q - CNT_ONE;
              if (gap_q != '0) begin
                state_d   = S_GAP;
                gap_cnt_d = gap_q;
              end
            end else begin
              state_d = S_FLUSH;
              flush_d = 1'b0;
            end
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q <= CNT_ONE) begin
            state_d   = S_PLAY;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q - CNT_ONE;
          end
        end
        S_FLUSH: begin
          // two cycles lets the last sample leave the memory and DAC registers
          if (flush_q) begin
            state_d = S_IDLE;
            flush_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            flush_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: registered memory strobe and a two-stage read/DAC pipeline
  always_comb begin
    mem_en_d = (state_d == S_PLAY);
    rd_vld_d = mem_en_q && !abort;
    dac_ce_d = rd_vld_q && !abort;
    dac0_d   = dac_ce_d ? mem_dat0 : '0;
    dac1_d   = dac_ce_d ? mem_dat1 : '0;
  end

  assign mem_en   = mem_en_q;
  assign mem_addr = addr_q;
  assign dac0     = dac0_q;
  assign dac1     = dac1_q;
  assign dac_ce   = dac_ce_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule
